// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wn,
    input  logic                  rn,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] DATAIN,
    output logic [DATA_WIDTH-1:0] DATAOUT,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // Flags decode only the registered count, so they never follow rn/wn directly.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok = rn & ~empty;
    assign wr_ok = wn & (~full | rd_ok);

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wptr] <= DATAIN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            DATAOUT    <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            if (rd_ok) begin
                DATAOUT <= mem[rptr];
                rptr    <= rptr + 1'b1;
            end
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set condition takes priority over a same-cycle clear.
            overflow  <= (wn & full & ~rd_ok) | (overflow & ~clr_err);
            underflow <= (rn & empty) | (underflow & ~clr_err);
        end
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x8 FIFO buffer.
- Configurable data width and depth.
- True simultaneous read/write, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags.
- Sits between a producer and consumer in the same clock domain; registered read data with a valid strobe.

Parameters:
DATA_WIDTH, 8, bits per word
DEPTH, 8, number of storage words; power of two, >= 4
ADDR_WIDTH, 3, log2(DEPTH); must match DEPTH
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH-1)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (1..DEPTH-1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
wn  input  1  write request
rn  input  1  read request
clr_err  input  1  synchronous clear of overflow/underflow
DATAIN  input  DATA_WIDTH  write data
DATAOUT  output  DATA_WIDTH  read data, registered
dout_valid  output  1  one-cycle strobe: DATAOUT updated this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Interface decision: one clock (clock); reset is asynchronous and active-low (reset low clears state immediately, independent of clock).
- Reset values:
  - wptr, rptr, count = 0; DATAOUT = 0; dout_valid = 0; overflow = underflow = 0.
  - Resulting flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory array is not reset.
- Pointers: ADDR_WIDTH-bit, wrap DEPTH-1 -> 0 by natural overflow. Occupancy is tracked in the count register.
- Read acceptance: rd_ok = rn & ~empty.
  - On rd_ok: DATAOUT <= mem[rptr]; rptr increments; dout_valid = 1 next cycle.
  - Otherwise DATAOUT holds and dout_valid = 0.
  - Read latency: 1 clock from the rn edge to DATAOUT/dout_valid.
- Write acceptance: wr_ok = wn & (~full | rd_ok).
  - On wr_ok: mem[wptr] <= DATAIN; wptr increments.
  - When full, a write is accepted only if a read is accepted in the same cycle.
- Simultaneous rd_ok & wr_ok: count unchanged; both pointers advance.
- Empty FIFO with wn & rn: write accepted, read rejected (no bypass), underflow sets; count becomes 1.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged otherwise.
  - Never exceeds DEPTH or goes below 0.
- Flags: all combinational decodes of the registered count, so they change exactly one clock after the causing edge; no glitch paths from rn/wn.
- Error flags:
  - overflow sets on wn & full & ~rd_ok.
  - underflow sets on rn & empty.
  - Both hold until clr_err = 1 (synchronous) or reset.
  - If clr_err and a set condition occur in the same cycle, set wins.
- Reset mid-operation: pointers/count clear asynchronously and any in-flight read is discarded. After reset deasserts, old memory contents are unreachable.
- DATA_WIDTH/DEPTH are generic; no hard-coded 8.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, DATAOUT=0, dout_valid=0.
- Write 0x11..0x18 (8 words, defaults) -> count steps 1..8; almost_full at count 6; full=1 after 8th write; 9th write with rn=0 -> count stays 8, overflow=1.
- From full, read 8 words -> DATAOUT 0x11..0x18 in order, each one clock after rn with dout_valid=1; empty=1 after the last; a further rn -> underflow=1, DATAOUT holds 0x18; clr_err -> underflow=0.
- At count 4, assert wn=rn for 20 cycles with incrementing data -> count stays 4; pointers wrap past 7 -> 0; read sequence matches write order.
- Full FIFO, wn=rn=1 with DATAIN=0xAA -> write accepted, count stays 8, overflow stays 0; empty FIFO with wn=rn=1 -> count=1, underflow=1, dout_valid=0.
- Pull reset low asynchronously mid-burst at count 5 -> count=0, empty=1 immediately; next write/read returns the newly written value only.
